// File: rtl/decode_stage_reg_if.sv
// decode_stage_reg_if
// Purpose: bundles every non-clock signal of the LEGv8 decode stage.
//   - IF/ID handshake: if_valid, if_instr in; if_ready out.
//   - Pipeline control: ex_stall, flush in; hazard_stall out.
//   - Registered ID/EX control word: id_* out.
//   - Hazard bubble counter: stall_cnt out.
// Modports:
//   master - the pipeline side that feeds instructions and consumes the ID/EX word
//   slave  - the decode stage itself
interface decode_stage_reg_if #(
  parameter int ADDR_W = 64
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic              if_ready;
  logic              ex_stall;
  logic              flush;
  logic              hazard_stall;
  logic              id_valid;
  logic [4:0]        id_rd;
  logic [4:0]        id_rn;
  logic [4:0]        id_rm;
  logic [2:0]        id_alu_op;
  logic [11:0]       id_imm12;
  logic              id_alu_src;
  logic              id_alu_imm;
  logic              id_set_flags;
  logic              id_reg_write;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              id_br_taken;
  logic              id_uncond_br;
  logic              id_br_zero;
  logic              id_br_lt;
  logic              id_illegal;
  logic [ADDR_W-1:0] id_br_offset;
  logic [15:0]       stall_cnt;

  modport master (
    output if_valid, if_instr, ex_stall, flush,
    input  if_ready, hazard_stall, id_valid, id_rd, id_rn, id_rm, id_alu_op,
           id_imm12, id_alu_src, id_alu_imm, id_set_flags, id_reg_write,
           id_mem_write, id_mem_to_reg, id_br_taken, id_uncond_br, id_br_zero,
           id_br_lt, id_illegal, id_br_offset, stall_cnt
  );

  modport slave (
    input  if_valid, if_instr, ex_stall, flush,
    output if_ready, hazard_stall, id_valid, id_rd, id_rn, id_rm, id_alu_op,
           id_imm12, id_alu_src, id_alu_imm, id_set_flags, id_reg_write,
           id_mem_write, id_mem_to_reg, id_br_taken, id_uncond_br, id_br_zero,
           id_br_lt, id_illegal, id_br_offset, stall_cnt
  );
endinterface

// File: rtl/decode_stage_reg.sv
// decode_stage_reg
// Purpose: LEGv8 instruction-decode stage. Decodes one instruction per cycle
// into a control word and captures it in an internal ID/EX register. Detects
// load-use hazards against the instruction already in ID/EX and inserts a
// one-cycle bubble for them, honours EX back-pressure and branch flush, marks
// unrecognised encodings as illegal and counts inserted bubbles (saturating).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset (clears ID/EX and stall_cnt)
//   bus   - decode_stage_reg_if.slave (handshake, control, id_* word, stall_cnt)
// Parameters:
//   ADDR_W     - width of the sign-extended branch offset
//   ENABLE_MUL - 0 makes the MUL encoding decode as illegal
module decode_stage_reg #(
  parameter int ADDR_W     = 64,
  parameter int ENABLE_MUL = 1
) (
  input  logic              clk,
  input  logic              reset,
  decode_stage_reg_if.slave bus
);

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_MUL  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_LSL  = 3'b111;
  localparam logic [4:0] XZR      = 5'd31;

  typedef struct packed {
    logic              valid;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [2:0]        alu_op;
    logic [11:0]       imm12;
    logic              alu_src;
    logic              alu_imm;
    logic              set_flags;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic              br_taken;
    logic              uncond_br;
    logic              br_zero;
    logic              br_lt;
    logic              illegal;
    logic [ADDR_W-1:0] br_offset;
  } idex_t;

  logic [31:0] instr;
  logic        is_addi, is_adds, is_subs, is_lsl, is_lsr, is_mul;
  logic        is_b, is_blt, is_cbz, is_ldur, is_stur;
  logic        known;
  logic        use_rn;
  logic        use_rm;
  logic        hazard;
  idex_t       dec;
  idex_t       id_d;
  idex_t       id_q;
  logic [15:0] stall_cnt_d;
  logic [15:0] stall_cnt_q;

  assign instr = bus.if_instr;

  // Opcode matches; the encodings are mutually exclusive.
  assign is_addi = (instr[31:22] == 10'b1001000100);
  assign is_adds = (instr[31:21] == 11'b10101011000);
  assign is_subs = (instr[31:21] == 11'b11101011000);
  assign is_lsl  = (instr[31:21] == 11'b11010011011);
  assign is_lsr  = (instr[31:21] == 11'b11010011010);
  assign is_mul  = (ENABLE_MUL != 0) && (instr[31:21] == 11'b10011011000);
  assign is_b    = (instr[31:26] == 6'b000101);
  assign is_blt  = (instr[31:24] == 8'b01010100);
  assign is_cbz  = (instr[31:24] == 8'b10110100);
  assign is_ldur = (instr[31:21] == 11'b11111000010);
  assign is_stur = (instr[31:21] == 11'b11111000000);

  assign known = is_addi | is_adds | is_subs | is_lsl | is_lsr | is_mul |
                 is_b | is_blt | is_cbz | is_ldur | is_stur;

  // Combinational decode of the instruction currently presented by IF/ID.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rd    = instr[4:0];
    // CBZ compares Rt against zero, so the Rn port reads XZR.
    dec.rn    = is_cbz ? XZR : instr[9:5];
    // STUR and CBZ read their second operand from the Rt field.
    dec.rm    = (is_stur | is_cbz) ? instr[4:0] : instr[20:16];

    dec.reg_write  = is_addi | is_adds | is_subs | is_lsl | is_lsr | is_mul | is_ldur;
    dec.alu_src    = is_addi | is_ldur | is_stur | is_lsl | is_lsr;
    dec.alu_imm    = is_addi;
    dec.set_flags  = is_adds | is_subs;
    dec.mem_to_reg = is_ldur;
    dec.mem_write  = is_stur;
    dec.br_taken   = is_b | is_blt | is_cbz;
    dec.uncond_br  = is_b;
    dec.br_zero    = is_cbz;
    dec.br_lt      = is_blt;
    dec.illegal    = ~known;

    if (is_addi | is_adds | is_ldur | is_stur | is_cbz) begin
      dec.alu_op = ALU_ADD;
    end else if (is_subs) begin
      dec.alu_op = ALU_SUB;
    end else if (is_mul) begin
      dec.alu_op = ALU_MUL;
    end else if (is_lsl) begin
      dec.alu_op = ALU_LSL;
    end else begin
      // LSR shares the all-zero code with "no ALU operation".
      dec.alu_op = ALU_NONE;
    end

    if (is_addi) begin
      dec.imm12 = instr[21:10];
    end else if (is_ldur | is_stur) begin
      dec.imm12 = {{3{instr[20]}}, instr[20:12]};
    end else if (is_lsl | is_lsr) begin
      dec.imm12 = {6'b000000, instr[15:10]};
    end else begin
      dec.imm12 = 12'd0;
    end

    if (is_b) begin
      dec.br_offset = {{(ADDR_W-26){instr[25]}}, instr[25:0]};
    end else if (is_blt | is_cbz) begin
      dec.br_offset = {{(ADDR_W-19){instr[23]}}, instr[23:5]};
    end else begin
      dec.br_offset = '0;
    end

    use_rn = is_addi | is_adds | is_subs | is_lsl | is_lsr | is_mul | is_ldur | is_stur;
    use_rm = is_adds | is_subs | is_mul | is_stur | is_cbz;
  end

  // A load in ID/EX whose destination feeds the incoming instruction forces a
  // bubble; XZR as destination never creates a dependency.
  assign hazard = bus.if_valid & id_q.valid & id_q.mem_to_reg & (id_q.rd != XZR) &
                  ((use_rn & (dec.rn == id_q.rd)) | (use_rm & (dec.rm == id_q.rd))) &
                  ~bus.flush;

  // Next ID/EX contents and bubble counter, in priority order.
  always_comb begin
    id_d        = id_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush) begin
      id_d = '0;
    end else if (bus.ex_stall) begin
      id_d = id_q;
    end else if (hazard) begin
      id_d = '0;
    end else if (bus.if_valid) begin
      id_d = dec;
    end else begin
      id_d = '0;
    end

    // Only a bubble that is actually inserted is counted.
    if (hazard & ~bus.ex_stall & (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // ID/EX register and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q        <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      id_q        <= id_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.if_ready      = ~bus.ex_stall & ~hazard;
  assign bus.hazard_stall  = hazard;
  assign bus.id_valid      = id_q.valid;
  assign bus.id_rd         = id_q.rd;
  assign bus.id_rn         = id_q.rn;
  assign bus.id_rm         = id_q.rm;
  assign bus.id_alu_op     = id_q.alu_op;
  assign bus.id_imm12      = id_q.imm12;
  assign bus.id_alu_src    = id_q.alu_src;
  assign bus.id_alu_imm    = id_q.alu_imm;
  assign bus.id_set_flags  = id_q.set_flags;
  assign bus.id_reg_write  = id_q.reg_write;
  assign bus.id_mem_write  = id_q.mem_write;
  assign bus.id_mem_to_reg = id_q.mem_to_reg;
  assign bus.id_br_taken   = id_q.br_taken;
  assign bus.id_uncond_br  = id_q.uncond_br;
  assign bus.id_br_zero    = id_q.br_zero;
  assign bus.id_br_lt      = id_q.br_lt;
  assign bus.id_illegal    = id_q.illegal;
  assign bus.id_br_offset  = id_q.br_offset;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage_reg.sv
// tb_decode_stage_reg: drives two decode stages (MUL enabled / disabled) with
// the same directed and random instruction streams and compares them every
// cycle against a table-driven reference model.
module tb_decode_stage_reg;
  localparam int ADDR_W = 64;

  localparam int O_ADDI = 0, O_ADDS = 1, O_SUBS = 2, O_LSL = 3, O_LSR = 4, O_MUL = 5;
  localparam int O_B = 6, O_BLT = 7, O_CBZ = 8, O_LDUR = 9, O_STUR = 10, O_NONE = 11;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [2:0]  alu_op;
    logic [11:0] imm12;
    logic        alu_src;
    logic        alu_imm;
    logic        set_flags;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        br_taken;
    logic        uncond_br;
    logic        br_zero;
    logic        br_lt;
    logic        illegal;
    logic [63:0] br_offset;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_stall, in_flush;
  logic [31:0] in_instr;
  bit          cnt_forced = 1'b0;
  bit          preset = 1'b0;
  int          n_total = 0;
  int          n_bad = 0;

  word_t m_w [2];
  int    m_cnt [2];

  always #5 clk = ~clk;

  decode_stage_reg_if #(.ADDR_W(ADDR_W)) bus0 ();
  decode_stage_reg_if #(.ADDR_W(ADDR_W)) bus1 ();

  assign bus0.if_valid = in_valid;
  assign bus0.if_instr = in_instr;
  assign bus0.ex_stall = in_stall;
  assign bus0.flush    = in_flush;
  assign bus1.if_valid = in_valid;
  assign bus1.if_instr = in_instr;
  assign bus1.ex_stall = in_stall;
  assign bus1.flush    = in_flush;

  decode_stage_reg #(.ADDR_W(ADDR_W), .ENABLE_MUL(1)) dut (.clk(clk), .reset(reset), .bus(bus0));
  decode_stage_reg #(.ADDR_W(ADDR_W), .ENABLE_MUL(0)) dut_nm (.clk(clk), .reset(reset), .bus(bus1));

  function automatic int op_len(int i);
    case (i)
      O_ADDI: return 10;
      O_B: return 6;
      O_BLT, O_CBZ: return 8;
      default: return 11;
    endcase
  endfunction

  function automatic logic [31:0] op_pat(int i);
    case (i)
      O_ADDI: return 32'b1001000100;
      O_ADDS: return 32'b10101011000;
      O_SUBS: return 32'b11101011000;
      O_LSL:  return 32'b11010011011;
      O_LSR:  return 32'b11010011010;
      O_MUL:  return 32'b10011011000;
      O_B:    return 32'b000101;
      O_BLT:  return 32'b01010100;
      O_CBZ:  return 32'b10110100;
      O_LDUR: return 32'b11111000010;
      default: return 32'b11111000000;
    endcase
  endfunction

  function automatic int classify(logic [31:0] ins, bit en_mul);
    for (int i = 0; i < 11; i++) begin
      if ((ins >> (32 - op_len(i))) == op_pat(i) && !(i == O_MUL && !en_mul)) return i;
    end
    return O_NONE;
  endfunction

  function automatic bit uses_rn(int op);
    return op inside {O_ADDI, O_ADDS, O_SUBS, O_LSL, O_LSR, O_MUL, O_LDUR, O_STUR};
  endfunction

  function automatic bit uses_rm(int op);
    return op inside {O_ADDS, O_SUBS, O_MUL, O_STUR, O_CBZ};
  endfunction

  function automatic word_t ref_decode(logic [31:0] ins, bit en_mul);
    word_t  w;
    int     op;
    int     v;
    longint off;
    op = classify(ins, en_mul);
    w = '0;
    w.valid = 1'b1;
    w.rd = ins[4:0];
    w.rn = (op == O_CBZ) ? 5'd31 : ins[9:5];
    w.rm = (op == O_STUR || op == O_CBZ) ? ins[4:0] : ins[20:16];
    w.illegal    = (op == O_NONE);
    w.reg_write  = op inside {O_ADDI, O_ADDS, O_SUBS, O_LSL, O_LSR, O_MUL, O_LDUR};
    w.alu_src    = op inside {O_ADDI, O_LDUR, O_STUR, O_LSL, O_LSR};
    w.alu_imm    = (op == O_ADDI);
    w.set_flags  = op inside {O_ADDS, O_SUBS};
    w.mem_to_reg = (op == O_LDUR);
    w.mem_write  = (op == O_STUR);
    w.br_taken   = op inside {O_B, O_BLT, O_CBZ};
    w.uncond_br  = (op == O_B);
    w.br_zero    = (op == O_CBZ);
    w.br_lt      = (op == O_BLT);
    case (op)
      O_ADDI, O_ADDS, O_LDUR, O_STUR, O_CBZ: w.alu_op = 3'b010;
      O_SUBS: w.alu_op = 3'b011;
      O_MUL:  w.alu_op = 3'b001;
      O_LSL:  w.alu_op = 3'b111;
      default: w.alu_op = 3'b000;
    endcase
    case (op)
      O_ADDI: w.imm12 = ins[21:10];
      O_LDUR, O_STUR: begin
        v = int'(ins[20:12]);
        if (v >= 256) v = v - 512;
        w.imm12 = 12'(v);
      end
      O_LSL, O_LSR: w.imm12 = 12'(ins[15:10]);
      default: w.imm12 = 12'd0;
    endcase
    case (op)
      O_B: begin
        off = longint'(ins[25:0]);
        if (off >= 64'sd33554432) off = off - 64'sd67108864;
        w.br_offset = 64'(off);
      end
      O_BLT, O_CBZ: begin
        off = longint'(ins[23:5]);
        if (off >= 64'sd262144) off = off - 64'sd524288;
        w.br_offset = 64'(off);
      end
      default: w.br_offset = 64'd0;
    endcase
    return w;
  endfunction

  function automatic bit exp_hazard(int k);
    word_t w;
    int    op;
    op = classify(in_instr, k == 0);
    w  = ref_decode(in_instr, k == 0);
    return in_valid && m_w[k].valid && m_w[k].mem_to_reg && m_w[k].rd != 5'd31 &&
           ((uses_rn(op) && w.rn == m_w[k].rd) || (uses_rm(op) && w.rm == m_w[k].rd)) &&
           !in_flush;
  endfunction

  // Reference model of the ID/EX register and bubble counter.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_w[k]   <= '0;
        m_cnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (in_flush) m_w[k] <= '0;
        else if (in_stall) m_w[k] <= m_w[k];
        else if (exp_hazard(k)) begin
          m_w[k] <= '0;
          if (m_cnt[k] < 65535) m_cnt[k] <= m_cnt[k] + 1;
        end
        else if (in_valid) m_w[k] <= ref_decode(in_instr, k == 0);
        else m_w[k] <= '0;
      end
      if (preset) m_cnt[0] <= 65520;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    word_t      aw [2];
    logic       ah [2];
    logic       ar [2];
    logic [15:0] ac [2];
    aw[0] = {bus0.id_valid, bus0.id_rd, bus0.id_rn, bus0.id_rm, bus0.id_alu_op, bus0.id_imm12,
             bus0.id_alu_src, bus0.id_alu_imm, bus0.id_set_flags, bus0.id_reg_write,
             bus0.id_mem_write, bus0.id_mem_to_reg, bus0.id_br_taken, bus0.id_uncond_br,
             bus0.id_br_zero, bus0.id_br_lt, bus0.id_illegal, bus0.id_br_offset};
    aw[1] = {bus1.id_valid, bus1.id_rd, bus1.id_rn, bus1.id_rm, bus1.id_alu_op, bus1.id_imm12,
             bus1.id_alu_src, bus1.id_alu_imm, bus1.id_set_flags, bus1.id_reg_write,
             bus1.id_mem_write, bus1.id_mem_to_reg, bus1.id_br_taken, bus1.id_uncond_br,
             bus1.id_br_zero, bus1.id_br_lt, bus1.id_illegal, bus1.id_br_offset};
    ah[0] = bus0.hazard_stall; ah[1] = bus1.hazard_stall;
    ar[0] = bus0.if_ready;     ar[1] = bus1.if_ready;
    ac[0] = bus0.stall_cnt;    ac[1] = bus1.stall_cnt;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hazard_stall[%0d]", k), 128'(ah[k]), 128'(exp_hazard(k)));
      chk($sformatf("if_ready[%0d]", k), 128'(ar[k]), 128'(!in_stall && !exp_hazard(k)));
      chk($sformatf("id_word[%0d]", k), 128'(aw[k]), 128'(m_w[k]));
      if (!(k == 0 && cnt_forced)) chk($sformatf("stall_cnt[%0d]", k), 128'(ac[k]), 128'(m_cnt[k]));
    end
  endtask

  // One cycle: compare on the falling edge, return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    in_valid = v; in_instr = ins; in_stall = st; in_flush = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [4:0] rand_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    int          op;
    int          len;
    logic [31:0] ins;
    op = $urandom_range(0, 13);
    if (op == 13) return $urandom();
    if (op >= 11) op = O_LDUR;
    len = op_len(op);
    ins = $urandom();
    ins = (op_pat(op) << (32 - len)) | (ins & (32'hFFFF_FFFF >> len));
    ins[4:0]   = rand_reg();
    ins[9:5]   = rand_reg();
    ins[20:16] = rand_reg();
    return ins;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    chk("reset_id_valid", 128'(bus0.id_valid), 128'(1'b0));
    chk("reset_stall_cnt", 128'(bus0.stall_cnt), 128'(16'd0));

    // ADDI X1,X2,#5
    drive(1'b1, 32'h91001441, 1'b0, 1'b0);
    tick();
    chk("addi_rd", 128'(bus0.id_rd), 128'(5'd1));
    chk("addi_rn", 128'(bus0.id_rn), 128'(5'd2));
    chk("addi_imm12", 128'(bus0.id_imm12), 128'(12'd5));
    chk("addi_alu_op", 128'(bus0.id_alu_op), 128'(3'b010));
    chk("addi_reg_write", 128'(bus0.id_reg_write), 128'(1'b1));
    chk("addi_alu_imm", 128'(bus0.id_alu_imm), 128'(1'b1));

    // LDUR X3,[X4] followed by dependent ADDS X5,X3,X6
    drive(1'b1, 32'hF8400083, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hAB060065, 1'b0, 1'b0);
    #1;
    chk("lu_hazard", 128'(bus0.hazard_stall), 128'(1'b1));
    chk("lu_if_ready", 128'(bus0.if_ready), 128'(1'b0));
    tick();
    chk("lu_bubble", 128'(bus0.id_valid), 128'(1'b0));
    chk("lu_cnt", 128'(bus0.stall_cnt), 128'(16'd1));
    tick();
    chk("lu_adds_valid", 128'(bus0.id_valid), 128'(1'b1));
    chk("lu_adds_rd", 128'(bus0.id_rd), 128'(5'd5));
    chk("lu_adds_flags", 128'(bus0.id_set_flags), 128'(1'b1));

    // Same pair held by ex_stall for three cycles
    do_reset();
    drive(1'b1, 32'hF8400083, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hAB060065, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("exs_hold_load", 128'(bus0.id_mem_to_reg), 128'(1'b1));
      chk("exs_cnt", 128'(bus0.stall_cnt), 128'(16'd0));
    end
    in_stall = 1'b0;
    tick();
    chk("exs_bubble", 128'(bus0.id_valid), 128'(1'b0));
    chk("exs_cnt_after", 128'(bus0.stall_cnt), 128'(16'd1));
    tick();
    chk("exs_adds_rd", 128'(bus0.id_rd), 128'(5'd5));

    // B -1, then the same with a concurrent flush
    drive(1'b1, 32'h17FFFFFF, 1'b0, 1'b0);
    tick();
    chk("b_offset", 128'(bus0.id_br_offset), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("b_uncond", 128'(bus0.id_uncond_br), 128'(1'b1));
    chk("b_taken", 128'(bus0.id_br_taken), 128'(1'b1));
    drive(1'b1, 32'h17FFFFFF, 1'b0, 1'b1);
    tick();
    chk("b_flush_valid", 128'(bus0.id_valid), 128'(1'b0));

    // All-zero encoding is illegal
    drive(1'b1, 32'h00000000, 1'b0, 1'b0);
    tick();
    chk("ill_illegal", 128'(bus0.id_illegal), 128'(1'b1));
    chk("ill_valid", 128'(bus0.id_valid), 128'(1'b1));
    chk("ill_ctrl", 128'({bus0.id_reg_write, bus0.id_mem_write, bus0.id_br_taken}), 128'(3'b000));

    // MUL X1,X2,X3 on both variants
    drive(1'b1, 32'h9B030041, 1'b0, 1'b0);
    tick();
    chk("mul_alu_op", 128'(bus0.id_alu_op), 128'(3'b001));
    chk("mul_illegal_en", 128'(bus0.id_illegal), 128'(1'b0));
    chk("mul_illegal_dis", 128'(bus1.id_illegal), 128'(1'b1));
    chk("mul_wr_dis", 128'(bus1.id_reg_write), 128'(1'b0));

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      drive(($urandom_range(0, 9) < 8), rand_instr(), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0));
      tick();
    end

    // Saturation: preload the counter near the top, then keep stalling
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    force dut.stall_cnt_q = 16'hFFF0;
    cnt_forced = 1'b1;
    preset = 1'b1;
    tick();
    release dut.stall_cnt_q;
    cnt_forced = 1'b0;
    preset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 32'hF8400063, 1'b0, 1'b0);
      tick();
    end
    chk("sat_cnt", 128'(bus0.stall_cnt), 128'(16'hFFFF));

    // Asynchronous reset in the middle of a load-use stall
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hF8400083, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hAB060065, 1'b0, 1'b0);
    #1;
    chk("ar_hazard_before", 128'(bus0.hazard_stall), 128'(1'b1));
    #1;
    reset = 1'b1;
    #1;
    chk("ar_id_valid", 128'(bus0.id_valid), 128'(1'b0));
    chk("ar_stall_cnt", 128'(bus0.stall_cnt), 128'(16'd0));
    chk("ar_hazard", 128'(bus0.hazard_stall), 128'(1'b0));
    tick();
    reset = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
